// File: rtl/fp_subtractor_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_subtractor_seq_pkg
// Brief   : Shared IEEE-754 single-precision constants, FSM state encodings
//           and small decode helpers for the sequential FP datapath blocks.
// Revision: 1.0 - initial release
// ============================================================================
package fp_subtractor_seq_pkg;

  localparam int          FP_EXP_W = 8;
  localparam int          FP_MAN_W = 23;
  localparam int          FP_BIAS  = 127;
  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
  localparam logic [31:0] FP_PINF  = 32'h7F800000;

  // 3-bit state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ALIGN  = 3'd1;
  localparam logic [2:0] ST_ADDSUB = 3'd2;
  localparam logic [2:0] ST_NORM   = 3'd3;
  localparam logic [2:0] ST_ROUND  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ALIGN  = ST_ALIGN,
    S_ADDSUB = ST_ADDSUB,
    S_NORM   = ST_NORM,
    S_ROUND  = ST_ROUND,
    S_DONE   = ST_DONE
  } state_t;

  // All-ones exponent with non-zero fraction
  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // All-ones exponent with zero fraction
  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc27.sv
`default_nettype none
// ============================================================================
// Module  : fp_lzc27
// Brief   : Combinational 27-bit leading-zero counter (27 for an all-zero
//           input). Shared by the sequential FP normalisers.
// Revision: 1.0 - initial release
// ============================================================================
module fp_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Priority scan from the MSB; first set bit fixes the count
  always_comb begin
    logic w_found;
    count   = 5'd27;
    w_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_found && value[i]) begin
        count   = 5'(26 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp_subtractor_seq
// Brief   : Multi-cycle IEEE-754 single-precision subtractor, out = in1 - in2.
//           Subtraction is an add with the subtrahend sign flipped. Denormal
//           operands and underflowing results are flushed to zero; rounding
//           is round-to-nearest-even. One operation in flight.
// Revision: 1.0 - initial release
// ============================================================================
module fp_subtractor_seq
  import fp_subtractor_seq_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out
);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [31:0]        r_out;
  logic [31:0]        r_a;         // minuend
  logic [31:0]        r_b;         // subtrahend, sign already flipped
  logic               r_sign;      // sign of the larger-magnitude operand
  logic               r_sub;       // effective subtraction of magnitudes
  logic signed [9:0]  r_exp;       // wide enough for over/underflow detect
  logic [26:0]        r_ma;        // {hidden, frac, G, R, S}
  logic [26:0]        r_mb;
  logic [27:0]        r_sum;       // extra MSB catches the add carry-out
  logic [26:0]        r_m;         // normalised mantissa with G/R/S
  logic               r_zero;
  logic               r_spec;
  logic [31:0]        r_spec_val;

  // ---------------- ALIGN: unpack, flush, swap, shift ----------------------
  logic               w_nan, w_inf_a, w_inf_b, w_swap;
  logic [30:0]        w_mag_a, w_mag_b, w_mag_big, w_mag_sml;
  logic [23:0]        w_man_big, w_man_sml;
  logic [7:0]         w_shift;
  logic [53:0]        w_sh_full;
  logic [26:0]        w_mb_al;
  logic [31:0]        w_spec_val;

  assign w_nan   = fp_is_nan(r_a) || fp_is_nan(r_b);
  assign w_inf_a = fp_is_inf(r_a);
  assign w_inf_b = fp_is_inf(r_b);
  // Zero-exponent operands collapse to a magnitude of zero, keeping sign
  assign w_mag_a   = (r_a[30:23] == 8'd0) ? 31'd0 : r_a[30:0];
  assign w_mag_b   = (r_b[30:23] == 8'd0) ? 31'd0 : r_b[30:0];
  assign w_swap    = (w_mag_b > w_mag_a);
  assign w_mag_big = w_swap ? w_mag_b : w_mag_a;
  assign w_mag_sml = w_swap ? w_mag_a : w_mag_b;
  assign w_man_big = (w_mag_big[30:23] == 8'd0) ? 24'd0 : {1'b1, w_mag_big[22:0]};
  assign w_man_sml = (w_mag_sml[30:23] == 8'd0) ? 24'd0 : {1'b1, w_mag_sml[22:0]};
  assign w_shift   = w_mag_big[30:23] - w_mag_sml[30:23];
  assign w_sh_full = {w_man_sml, 3'b000, 27'd0} >> w_shift;
  // Shifts of 27 or more would push bits past the window, keep only sticky
  assign w_mb_al   = (w_shift >= 8'd27) ? {26'd0, |w_man_sml}
                                        : {w_sh_full[53:28], w_sh_full[27] | (|w_sh_full[26:0])};
  // inf + (-inf) after the sign flip is invalid; otherwise the infinity wins
  assign w_spec_val = (w_nan || (w_inf_a && w_inf_b && (r_a[31] != r_b[31]))) ? FP_QNAN :
                      w_inf_a ? r_a : r_b;

  // ---------------- NORM: leading-zero count ------------------------------
  logic [4:0]         w_lzc;

  fp_lzc27 u_lzc (
    .value (r_sum[26:0]),
    .count (w_lzc)
  );

  // ---------------- ROUND: nearest-even, range check ----------------------
  logic               w_rup;
  logic [24:0]        w_rm;
  logic signed [9:0]  w_re;
  logic [22:0]        w_frac;
  logic [31:0]        w_result;

  assign w_rup  = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_rm   = {1'b0, r_m[26:3]} + {24'd0, w_rup};
  assign w_re   = r_exp + $signed({9'd0, w_rm[24]});
  assign w_frac = w_rm[24] ? w_rm[23:1] : w_rm[22:0];

  always_comb begin
    w_result = {r_sign, w_re[7:0], w_frac};
    if (r_spec)                    w_result = r_spec_val;
    else if (r_zero)               w_result = {r_sign, 31'd0};
    else if (w_re >= 10'sd255)     w_result = {r_sign, FP_PINF[30:0]};
    else if (w_re <= 10'sd0)       w_result = 32'h0000_0000;
  end

  // ---------------- Control FSM and datapath registers --------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= 32'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= 10'sd0;
      r_ma        <= 27'd0;
      r_mb        <= 27'd0;
      r_sum       <= 28'd0;
      r_m         <= 27'd0;
      r_zero      <= 1'b0;
      r_spec      <= 1'b0;
      r_spec_val  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in1;
            r_b        <= {~in2[31], in2[30:0]};
            r_in_ready <= 1'b0;
            r_state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_spec     <= w_nan || w_inf_a || w_inf_b;
          r_spec_val <= w_spec_val;
          r_sign     <= w_swap ? r_b[31] : r_a[31];
          r_sub      <= (r_a[31] != r_b[31]);
          r_exp      <= $signed({2'b00, w_mag_big[30:23]});
          r_ma       <= {w_man_big, 3'b000};
          r_mb       <= w_mb_al;
          r_zero     <= 1'b0;
          r_state    <= S_ADDSUB;
        end
        S_ADDSUB: begin
          r_sum   <= r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum == 28'd0) begin
            // Exact cancellation is +0; adding two zeros keeps their sign
            r_zero <= 1'b1;
            if (r_sub) r_sign <= 1'b0;
          end else if (r_sum[27]) begin
            r_m   <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 10'sd1;
          end else begin
            r_m   <= r_sum[26:0] << w_lzc;
            r_exp <= r_exp - $signed({5'd0, w_lzc});
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_out   <= w_result;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle raises the registered valid; it then holds
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_subtractor_seq
// Brief   : Directed self-checking bench for fp_subtractor_seq.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_subtractor_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int n_checks;
  int n_errors;

  fp_subtractor_seq #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one subtraction and check latency, result and return to IDLE
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int k;
    int lat;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_out"}, out, exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld0"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = 32'h0;
    in2       = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_out", out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("neg08", 32'hBF4CCCCD, 32'hBF19999A, 32'hBE4CCCCC);
    run_op("xmx",   32'h3F800000, 32'h3F800000, 32'h00000000);
    run_op("addm",  32'h3FC00000, 32'hC0200000, 32'h40800000);
    run_op("tie",   32'h3F800000, 32'h33000000, 32'h3F800000);
    run_op("ovf",   32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000);
    run_op("infinf",32'h7F800000, 32'h7F800000, 32'h7FC00000);
    run_op("fminf", 32'h3F800000, 32'hFF800000, 32'h7F800000);
    run_op("finpinf",32'h3F800000,32'h7F800000, 32'hFF800000);
    run_op("infmf", 32'hFF800000, 32'h3F800000, 32'hFF800000);
    run_op("nan1",  32'h7F800001, 32'h3F800000, 32'h7FC00000);
    run_op("nan2",  32'h3F800000, 32'hFFC00000, 32'h7FC00000);
    run_op("nzpz",  32'h80000000, 32'h00000000, 32'h80000000);
    run_op("pzpz",  32'h00000000, 32'h00000000, 32'h00000000);
    run_op("swap",  32'h3F800000, 32'h40000000, 32'hBF800000);
    run_op("twom1", 32'h40000000, 32'h3F800000, 32'h3F800000);
    run_op("denf",  32'h00800000, 32'h00400000, 32'h00800000);
    run_op("unf",   32'h00C00000, 32'h00800000, 32'h00000000);

    // Backpressure: result held while out_ready is low
    begin
      int k;
      out_ready = 1'b0;
      in1 = 32'h3FC00000; in2 = 32'hC0200000; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      for (int i = 0; i < 10; i++) begin
        check("bp_vld", {31'd0, out_valid}, 32'd1);
        check("bp_out", out, 32'h40800000);
        check("bp_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_rel_vld", {31'd0, out_valid}, 32'd0);
      check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
      run_op("bp_next", 32'h40000000, 32'h3F800000, 32'h3F800000);
    end

    // Reset while the operation sits in NORM
    in1 = 32'h3F800000; in2 = 32'hBF800000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_vld", {31'd0, out_valid}, 32'd0);
    check("ar_rdy", {31'd0, in_ready}, 32'd1);
    check("ar_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ar_stale", {31'd0, out_valid}, 32'd0);
    end
    run_op("ar_next", 32'hBF4CCCCD, 32'hBF19999A, 32'hBE4CCCCC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
